// File: rtl/pwm_pkg.sv
// Shared constants and types for the shadowed PWM generator.
package pwm_pkg;

    // Default width of the cycle/duty words and of the period counter.
    localparam int unsigned PWM_WIDTH = 28;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FAULT
    } pwm_state_e;

endpackage

// File: rtl/pwm_shadow_gen_if.sv
// PIO-side bundle: firmware words in, PWM status out.
interface pwm_shadow_gen_if #(
    parameter int unsigned WIDTH = pwm_pkg::PWM_WIDTH
);
    logic             enable_in;
    logic [WIDTH-1:0] cycle_in;
    logic [WIDTH-1:0] duty_in;
    logic             pwm_out;
    logic             period_tick;
    logic             cfg_err;
    logic             busy_pending;

    // Firmware / PIO side.
    modport master (
        output enable_in, cycle_in, duty_in,
        input  pwm_out, period_tick, cfg_err, busy_pending
    );

    // PWM generator side.
    modport slave (
        input  enable_in, cycle_in, duty_in,
        output pwm_out, period_tick, cfg_err, busy_pending
    );
endinterface

// File: rtl/pwm_word_filter.sv
// Stability filter for the non-atomic cycle/duty PIO words plus the pending shadow pair.
module pwm_word_filter
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH         = PWM_WIDTH,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] cycle_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic [WIDTH-1:0] act_cycle_i,
    input  logic [WIDTH-1:0] act_duty_i,
    input  logic             apply_i,
    output logic             pend_valid_o,
    output logic [WIDTH-1:0] pend_cycle_o,
    output logic [WIDTH-1:0] pend_duty_o
);
    localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] prev_cycle_q, prev_duty_q;
    logic [WIDTH-1:0] pend_cycle_q, pend_cycle_d, pend_duty_q, pend_duty_d;
    logic [CntW-1:0]  stable_cnt_q, stable_cnt_d;
    logic             pend_valid_q, pend_valid_d;
    logic             stable, reach, same_act, same_pend, capture;

    // Stability count, capture of a new settled pair, apply/cancel of the pending pair.
    always_comb begin
        stable       = (cycle_i == prev_cycle_q) && (duty_i == prev_duty_q);
        stable_cnt_d = stable_cnt_q;
        if (!stable) begin
            stable_cnt_d = '0;
        end else if (stable_cnt_q != CntMax) begin
            stable_cnt_d = stable_cnt_q + 1'b1;
        end
        reach     = stable && (stable_cnt_d == CntMax);
        same_act  = (prev_cycle_q == act_cycle_i) && (prev_duty_q == act_duty_i);
        same_pend = pend_valid_q && (prev_cycle_q == pend_cycle_q) && (prev_duty_q == pend_duty_q);
        // Counter saturates, so suppress re-capturing a pair already pending or active.
        capture   = reach && !same_act && !same_pend;

        pend_cycle_d = pend_cycle_q;
        pend_duty_d  = pend_duty_q;
        pend_valid_d = pend_valid_q;
        if (capture) begin
            pend_cycle_d = prev_cycle_q;
            pend_duty_d  = prev_duty_q;
            pend_valid_d = 1'b1;
        end else if (apply_i || (reach && same_act)) begin
            // Settling back onto the active pair cancels a stale pending pair.
            pend_valid_d = 1'b0;
        end
    end

    // Filter and pending registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_cycle_q <= '0;
            prev_duty_q  <= '0;
            stable_cnt_q <= '0;
            pend_cycle_q <= '0;
            pend_duty_q  <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            prev_cycle_q <= cycle_i;
            prev_duty_q  <= duty_i;
            stable_cnt_q <= stable_cnt_d;
            pend_cycle_q <= pend_cycle_d;
            pend_duty_q  <= pend_duty_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_cycle_o = pend_cycle_q;
    assign pend_duty_o  = pend_duty_q;

endmodule

// File: rtl/pwm_shadow_gen.sv
// Glitch-free PWM with shadowed period/duty applied only at period boundaries.
module pwm_shadow_gen
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH         = PWM_WIDTH,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MIN_CYCLE     = 2
) (
    input logic             clk_clk,
    input logic             reset_reset,
    pwm_shadow_gen_if.slave pio
);
    localparam logic [WIDTH-1:0] MinCycle = WIDTH'(MIN_CYCLE);

    pwm_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] act_cycle_q, act_cycle_d, act_duty_q, act_duty_d;
    logic             pwm_q, pwm_d, tick_q, tick_d;
    logic             pend_valid, apply, wrap, legal;
    logic [WIDTH-1:0] pend_cycle, pend_duty;

    pwm_word_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk_i        (clk_clk),
        .rst_i        (reset_reset),
        .cycle_i      (pio.cycle_in),
        .duty_i       (pio.duty_in),
        .act_cycle_i  (act_cycle_q),
        .act_duty_i   (act_duty_q),
        .apply_i      (apply),
        .pend_valid_o (pend_valid),
        .pend_cycle_o (pend_cycle),
        .pend_duty_o  (pend_duty)
    );

    // Next state, counter, apply and registered output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        apply   = 1'b0;
        wrap    = (cnt_q == act_cycle_q - WIDTH'(1));

        unique case (state_q)
            S_RUN: begin
                apply = pend_valid && wrap;
                cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
            end
            default: apply = pend_valid;
        endcase

        act_cycle_d = apply ? pend_cycle : act_cycle_q;
        act_duty_d  = apply ? pend_duty : act_duty_q;
        legal       = (act_cycle_d >= MinCycle);

        unique case (state_q)
            S_IDLE: begin
                if (pio.enable_in) state_d = legal ? S_RUN : S_FAULT;
            end
            S_RUN: begin
                if (wrap && !legal) state_d = S_FAULT;
            end
            S_FAULT: begin
                if (apply && legal) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase

        if (!pio.enable_in) state_d = S_IDLE;
        if (state_d != S_RUN) cnt_d = '0;

        // Outputs are computed from next state so the pins come straight off flops.
        pwm_d  = (state_d == S_RUN) && (cnt_d < act_duty_d);
        tick_d = (state_d == S_RUN) && (cnt_d == '0);
    end

    // State, counter, active words and output registers.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            act_cycle_q <= '0;
            act_duty_q  <= '0;
            pwm_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_cycle_q <= act_cycle_d;
            act_duty_q  <= act_duty_d;
            pwm_q       <= pwm_d;
            tick_q      <= tick_d;
        end
    end

    assign pio.pwm_out      = pwm_q;
    assign pio.period_tick  = tick_q;
    assign pio.cfg_err      = (state_q == S_FAULT);
    assign pio.busy_pending = pend_valid;

endmodule

// File: tb/tb_pwm_shadow_gen.sv
// Directed self-checking bench for pwm_shadow_gen.
module tb_pwm_shadow_gen;
    import pwm_pkg::*;

    localparam int unsigned W = PWM_WIDTH;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pwm_shadow_gen_if #(.WIDTH(W)) pio ();

    pwm_shadow_gen #(
        .WIDTH         (W),
        .STABLE_CYCLES (4),
        .MIN_CYCLE     (2)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .pio         (pio)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; sample point is 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Walk the current period from index start until the next tick, checking length and shape.
    task automatic measure(input string tag, input int start, input int exp_len, input int exp_high);
        int i = start;
        int shape_err = 0;
        if (start == 0) check({tag, "_tick0"}, pio.period_tick, 1);
        do begin
            if (pio.pwm_out !== ((i < exp_high) ? 1'b1 : 1'b0)) shape_err++;
            step(1);
            i++;
        end while (pio.period_tick !== 1'b1 && i < 200);
        check({tag, "_len"}, i, exp_len);
        check({tag, "_shape"}, shape_err, 0);
    endtask

    task automatic set_words(input int c, input int d);
        pio.cycle_in = W'(c);
        pio.duty_in  = W'(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        pio.enable_in = 1'b0;
        set_words(0, 0);
        step(2);
        check("rst_pwm", pio.pwm_out, 0);
        check("rst_tick", pio.period_tick, 0);
        check("rst_err", pio.cfg_err, 0);
        check("rst_busy", pio.busy_pending, 0);

        // 1: basic 10/3 after the filter settles, applied while idle.
        rst = 1'b0;
        set_words(10, 3);
        step(3);
        check("t1_busy_early", pio.busy_pending, 0);
        step(1);
        check("t1_busy_set", pio.busy_pending, 1);
        step(1);
        check("t1_busy_clr", pio.busy_pending, 0);
        pio.enable_in = 1'b1;
        step(1);
        check("t1_first_pwm", pio.pwm_out, 1);
        check("t1_err", pio.cfg_err, 0);
        measure("t1a", 0, 10, 3);
        measure("t1b", 0, 10, 3);

        // 2: change at cnt=4; running period completes, then 20/5.
        step(4);
        set_words(20, 5);
        measure("t2_old", 4, 10, 3);
        measure("t2_new", 0, 20, 5);

        // 3: cycle then duty two clocks later; intermediate pair never used.
        set_words(12, 5);
        step(2);
        set_words(12, 2);
        measure("t3_old", 2, 20, 5);
        measure("t3_new", 0, 12, 2);
        measure("t3_new2", 0, 12, 2);

        // 4: duty=0 gives constant low, duty>=cycle constant high.
        set_words(10, 0);
        measure("t4_prev", 0, 12, 2);
        measure("t4_zero", 0, 10, 0);
        set_words(10, 15);
        measure("t4_zero_b", 0, 10, 0);
        measure("t4_full", 0, 10, 15);
        measure("t4_full_b", 0, 10, 15);

        // 6a: enable drop forces low on the next edge; re-enable restarts the period.
        pio.enable_in = 1'b0;
        step(1);
        check("t6_dis_pwm", pio.pwm_out, 0);
        check("t6_dis_tick", pio.period_tick, 0);
        step(2);
        check("t6_dis_hold", pio.pwm_out, 0);
        pio.enable_in = 1'b1;
        step(1);
        check("t6_reen_tick", pio.period_tick, 1);
        check("t6_reen_pwm", pio.pwm_out, 1);
        step(2);
        check("t6_high", pio.pwm_out, 1);

        // 6b: async reset mid-high drops the output without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_pwm", pio.pwm_out, 0);
        check("t6_async_err", pio.cfg_err, 0);
        check("t6_async_busy", pio.busy_pending, 0);

        // 5: illegal period -> FAULT, then a legal pair recovers into RUN.
        pio.enable_in = 1'b0;
        set_words(1, 0);
        step(2);
        rst = 1'b0;
        step(6);
        check("t5_idle_err", pio.cfg_err, 0);
        check("t5_idle_busy", pio.busy_pending, 0);
        pio.enable_in = 1'b1;
        step(1);
        check("t5_fault_err", pio.cfg_err, 1);
        check("t5_fault_pwm", pio.pwm_out, 0);
        check("t5_fault_tick", pio.period_tick, 0);
        step(3);
        check("t5_fault_hold", pio.cfg_err, 1);
        set_words(8, 2);
        step(4);
        check("t5_pend_err", pio.cfg_err, 1);
        check("t5_pend_busy", pio.busy_pending, 1);
        step(1);
        check("t5_run_err", pio.cfg_err, 0);
        check("t5_run_busy", pio.busy_pending, 0);
        check("t5_run_pwm", pio.pwm_out, 1);
        measure("t5_run", 0, 8, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
